// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/accumulate unit: operation codes
// (single source for the ALU control decoder too), FSM states and defaults.
package hilo_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [5:0] OP_MULT  = 6'h03;
    localparam logic [5:0] OP_MULTU = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h13;
    localparam logic [5:0] OP_MADD  = 6'h14;
    localparam logic [5:0] OP_MSUB  = 6'h15;
    localparam logic [5:0] OP_MFHI  = 6'h17;
    localparam logic [5:0] OP_MFLO  = 6'h18;
    localparam logic [5:0] OP_MTHI  = 6'h19;
    localparam logic [5:0] OP_MTLO  = 6'h1A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } hilo_state_e;

    // Operations that run through the iterative multiplier.
    function automatic logic is_mult_op(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL) ||
               (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Moves complete in a single IDLE cycle.
    function automatic logic is_move_op(input logic [5:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO) ||
               (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    // Multiplies whose operands are treated as two's complement.
    function automatic logic is_signed_op(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MUL) ||
               (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mult_iter_32.sv
// Shift-add unsigned multiplier datapath. 'start' loads the operands and
// clears the partial product; each 'step' cycle performs one iteration.
// 'last' is high during the step that completes the final iteration.
module mult_iter_32 #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           step,
    input  logic [W-1:0]   mcand_in,
    input  logic [W-1:0]   mplier_in,
    output logic [2*W-1:0] product,
    output logic           last
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Load on start, otherwise add-if-LSB-set and shift on each step.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{W{1'b0}}, mcand_in};
            mplier_d = mplier_in;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product = prod_q;
    assign last    = step && (cnt_q == CNT_LAST);

endmodule

// File: rtl/hilo_mult_unit.sv
// Iterative multiply/accumulate unit with architectural HI/LO registers.
// Handshake: an op is accepted in a cycle where OpValid=1, Busy=0 and the
// code is recognised; Done pulses once when it completes, ResultValid pulses
// alongside Done when Result was rewritten (MUL, MFHI, MFLO).
module hilo_mult_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [5:0]       ALUControl,
    input  logic             OpValid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             ResultValid,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output hilo_state_e      dbg_state
);

    hilo_state_e      state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             rv_q, rv_d;

    logic               issue;
    logic               mult_start;
    logic               mult_last;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] raw_prod;
    logic [2*WIDTH-1:0] signed_prod;
    logic [2*WIDTH-1:0] hilo_new;

    assign issue = OpValid && (state_q == IDLE) &&
                   (is_mult_op(ALUControl) || is_move_op(ALUControl));

    // Magnitudes feed the unsigned core; -2^(W-1) maps to 2^(W-1) unsigned.
    always_comb begin
        a_mag = A;
        b_mag = B;
        if (is_signed_op(ALUControl)) begin
            if (A[WIDTH-1]) a_mag = -A;
            if (B[WIDTH-1]) b_mag = -B;
        end
    end

    mult_iter_32 #(.W(WIDTH)) u_iter (
        .clk       (Clk),
        .rst       (Rst),
        .start     (mult_start),
        .step      (state_q == CALC),
        .mcand_in  (a_mag),
        .mplier_in (b_mag),
        .product   (raw_prod),
        .last      (mult_last)
    );

    // Next-state, issue decode and FINISH write-back.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        neg_d       = neg_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        done_d      = 1'b0;
        rv_d        = 1'b0;
        mult_start  = 1'b0;
        signed_prod = neg_q ? -raw_prod : raw_prod;
        hilo_new    = {hi_q, lo_q};

        case (state_q)
            IDLE: begin
                if (issue) begin
                    if (is_mult_op(ALUControl)) begin
                        mult_start = 1'b1;
                        op_d       = ALUControl;
                        neg_d      = is_signed_op(ALUControl) && (A[WIDTH-1] ^ B[WIDTH-1]);
                        state_d    = CALC;
                    end else begin
                        done_d = 1'b1;
                        case (ALUControl)
                            OP_MTHI: hi_d = A;
                            OP_MTLO: lo_d = A;
                            OP_MFHI: begin
                                result_d = hi_q;
                                rv_d     = 1'b1;
                            end
                            OP_MFLO: begin
                                result_d = lo_q;
                                rv_d     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CALC: begin
                if (mult_last) state_d = FINISH;
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
                case (op_q)
                    OP_MADD: hilo_new = {hi_q, lo_q} + signed_prod;
                    OP_MSUB: hilo_new = {hi_q, lo_q} - signed_prod;
                    OP_MUL:  hilo_new = {hi_q, lo_q};
                    default: hilo_new = signed_prod;
                endcase
                hi_d = hilo_new[2*WIDTH-1:WIDTH];
                lo_d = hilo_new[WIDTH-1:0];
                if (op_q == OP_MUL) begin
                    result_d = signed_prod[WIDTH-1:0];
                    rv_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Architectural and control registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            done_q   <= done_d;
            rv_q     <= rv_d;
        end
    end

    assign Busy        = (state_q != IDLE);
    assign Done        = done_q;
    assign ResultValid = rv_q;
    assign Result      = result_q;
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed plus randomized checks of hilo_mult_unit against an arithmetic
// reference model of HI, LO and Result.
module tb_hilo_mult_unit;
    import hilo_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [5:0]  ALUControl;
    logic        OpValid;
    logic [31:0] A, B;
    logic        Busy, Done, ResultValid;
    logic [31:0] Result, HI, LO;
    hilo_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_hi, ref_lo, ref_result;

    hilo_mult_unit #(.WIDTH(32)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .ALUControl  (ALUControl),
        .OpValid     (OpValid),
        .A           (A),
        .B           (B),
        .Busy        (Busy),
        .Done        (Done),
        .Result      (Result),
        .ResultValid (ResultValid),
        .HI          (HI),
        .LO          (LO),
        .dbg_state   (dbg_state)
    );

    // Clock.
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic is_mul(input logic [5:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic is_mv(input logic [5:0] op);
        return op inside {OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
    endfunction

    // Reference model: plain 64-bit arithmetic on the architectural state.
    function automatic void model_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] p, acc;
        sa  = $signed(a);
        sb  = $signed(b);
        acc = {ref_hi, ref_lo};
        if (op == OP_MULTU) p = {32'b0, a} * {32'b0, b};
        else                p = sa * sb;
        case (op)
            OP_MULT, OP_MULTU: {ref_hi, ref_lo} = p;
            OP_MADD:           {ref_hi, ref_lo} = acc + p;
            OP_MSUB:           {ref_hi, ref_lo} = acc - p;
            OP_MUL:            ref_result = p[31:0];
            OP_MTHI:           ref_hi = a;
            OP_MTLO:           ref_lo = a;
            OP_MFHI:           ref_result = ref_hi;
            OP_MFLO:           ref_result = ref_lo;
            default: ;
        endcase
    endfunction

    // Drive one issue cycle; returns one cycle later with OpValid low.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUControl = op;
        A          = a;
        B          = b;
        OpValid    = 1'b1;
        tick();
        OpValid    = 1'b0;
    endtask

    // Issue any op, wait for completion and compare all outputs to the model.
    // Returns sitting in the Done cycle (or the cycle after an ignored op).
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat, busy_n;
        logic exp_rv;
        exp_rv = (op == OP_MUL) || (op == OP_MFHI) || (op == OP_MFLO);
        model_op(op, a, b);
        issue(op, a, b);
        if (is_mul(op)) begin
            lat    = 0;
            busy_n = 0;
            for (int i = 1; i <= 40; i++) begin
                if (Done) begin
                    lat = i;
                    break;
                end
                if (Busy) busy_n++;
                tick();
            end
            check({tag, "_latency"}, lat, 34);
            check({tag, "_busy_cycles"}, busy_n, 33);
            check({tag, "_busy_at_done"}, Busy, 1'b0);
        end else if (is_mv(op)) begin
            check({tag, "_done"}, Done, 1'b1);
        end else begin
            check({tag, "_no_done"}, Done, 1'b0);
            check({tag, "_no_busy"}, Busy, 1'b0);
            exp_rv = 1'b0;
        end
        check({tag, "_rv"}, ResultValid, exp_rv);
        check({tag, "_hi"}, HI, ref_hi);
        check({tag, "_lo"}, LO, ref_lo);
        check({tag, "_result"}, Result, ref_result);
    endtask

    logic [5:0] op_tab [10];
    logic [31:0] corner_tab [6];

    initial begin
        int done_n;
        logic [31:0] ra, rb;
        op_tab     = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB,
                       OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, 6'h00};
        corner_tab = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};

        // Reset.
        Rst = 1'b1; OpValid = 1'b0; ALUControl = '0; A = '0; B = '0;
        ref_hi = '0; ref_lo = '0; ref_result = '0;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("reset_busy", Busy, 1'b0);
        check("reset_done", Done, 1'b0);
        check("reset_rv", ResultValid, 1'b0);
        check("reset_hi", HI, 32'h0);
        check("reset_lo", LO, 32'h0);
        check("reset_result", Result, 32'h0);

        // Directed multiplies and accumulates.
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max_hi_const", HI, 32'hFFFFFFFE);
        check("multu_max_lo_const", LO, 32'h00000001);
        run_op("mult_minmin", OP_MULT, 32'h80000000, 32'h80000000);
        check("mult_minmin_hi_const", HI, 32'h40000000);
        run_op("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'd5);
        check("mult_m3x5_lo_const", LO, 32'hFFFFFFF1);
        run_op("mthi", OP_MTHI, 32'h0, 32'h0);
        run_op("mtlo", OP_MTLO, 32'd10, 32'h0);
        run_op("madd", OP_MADD, 32'd2, 32'd3);
        check("madd_lo_const", LO, 32'd16);
        run_op("msub", OP_MSUB, 32'd4, 32'd5);
        check("msub_hi_const", HI, 32'hFFFFFFFF);
        check("msub_lo_const", LO, 32'hFFFFFFFC);
        run_op("mflo", OP_MFLO, 32'h0, 32'h0);
        check("mflo_result_const", Result, 32'hFFFFFFFC);
        run_op("mul", OP_MUL, 32'd7, 32'hFFFFFFFE);
        check("mul_result_const", Result, 32'hFFFFFFF2);

        // MFLO offered while Busy is ignored: exactly one Done, Result untouched.
        model_op(OP_MULT, 32'd9, 32'd11);
        issue(OP_MULT, 32'd9, 32'd11);
        tick(); tick(); tick();
        ALUControl = OP_MFLO; OpValid = 1'b1;
        tick();
        OpValid = 1'b0;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done) done_n++;
            tick();
        end
        check("busy_ignore_done_count", done_n, 1);
        check("busy_ignore_result", Result, ref_result);
        check("busy_ignore_lo", LO, ref_lo);

        // Reset during CALC cycle 10 aborts with no Done.
        issue(OP_MULTU, 32'h1234, 32'h5678);
        repeat (9) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        ref_hi = '0; ref_lo = '0; ref_result = '0;
        check("abort_busy", Busy, 1'b0);
        check("abort_hi", HI, 32'h0);
        check("abort_lo", LO, 32'h0);
        check("abort_result", Result, 32'h0);
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done) done_n++;
            tick();
        end
        check("abort_done_count", done_n, 0);

        // Back-to-back: MULTU issued in the Done cycle of a MULT.
        run_op("b2b_first", OP_MULT, 32'hFFFF0000, 32'h00012345);
        run_op("b2b_second", OP_MULTU, 32'hDEADBEEF, 32'h00C0FFEE);
        run_op("bad_code", 6'h00, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Randomized ops, including the unlisted code and corner operands.
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            op = op_tab[$urandom_range(0, 9)];
            ra = ($urandom_range(0, 3) == 0) ? corner_tab[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner_tab[$urandom_range(0, 5)] : $urandom;
            run_op($sformatf("rand%0d", n), op, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_mult_unit.md
# hilo_mult_unit

Iterative multiply/accumulate unit with architectural HI/LO registers. It sits directly downstream of the ALU control decoder and consumes its 6-bit ALUControl code for MULT, MULTU, MUL, MADD, MSUB, MFHI, MFLO, MTHI and MTLO. It runs a 32-iteration shift-add multiply and stalls the pipeline through a Busy flag. It returns 32-bit results to the execute stage.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH; product width is 2*WIDTH.
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- ALUControl  in  6  operation code from ALU control: MULT=0x03, MULTU=0x04, MUL=0x13, MADD=0x14, MSUB=0x15, MFHI=0x17, MFLO=0x18, MTHI=0x19, MTLO=0x1A.
- OpValid  in  1  issue strobe; sampled only when Busy=0.
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- Busy  out  1  multiply in progress; upstream holds issue while high.
- Done  out  1  one-cycle pulse: operation completed.
- Result  out  WIDTH  MUL low product, or MFHI/MFLO value; holds its value until the next Result-producing op.
- ResultValid  out  1  one-cycle pulse: Result updated this cycle (MUL, MFHI, MFLO only).
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

## Operation
- Reset: state IDLE, HI=LO=Result=0, Busy=Done=ResultValid=0. Any in-flight operation is discarded.
- Issue condition: OpValid=1, Busy=0, and ALUControl is one of the nine codes. Any other code, or OpValid while Busy=1, is ignored with no Done.
- Moves (MTHI/MTLO/MFHI/MFLO): complete in IDLE. MTHI/MTLO write A into HI/LO. MFHI/MFLO copy HI/LO into Result.
- Multiplies: latch |A|, |B|, neg = A[31]^B[31] (signed ops only), op code, and clear the 64-bit accumulator. |-2^31| = 0x80000000 unsigned.
- States:
  - IDLE→CALC on multiply issue.
  - CALC: 32 iterations. Each iteration adds the multiplicand when the multiplier LSB is 1, then shifts. A 5-bit counter steps 0..31; CALC→FINISH at count 31.
  - FINISH: apply two's-complement negate if neg, then by op:
    - MULT/MULTU: {HI,LO}=P.
    - MADD: {HI,LO}+=P, mod 2^64.
    - MSUB: {HI,LO}-=P, mod 2^64.
    - MUL: Result=P[31:0], HI/LO unchanged.
  - FINISH→IDLE.
- MULTU: no sign handling. MADD/MSUB: signed.

## Timing
- Multiply issued in cycle t:
  - Busy=1 in cycles t+1..t+33 (CALC t+1..t+32, FINISH t+33).
  - HI/LO/Result written at the edge ending t+33.
  - Done=1 and Busy=0 in t+34; a new op may issue in t+34.
  - ResultValid=1 in t+34 for MUL only.
- Move issued in cycle t: register written at the edge ending t; Done=1 in t+1 (ResultValid=1 in t+1 for MFHI/MFLO). Busy stays 0, so moves may issue back-to-back every cycle.
- HI/LO outputs reflect the registers directly: new value visible in the Done cycle.
- Rst asserted in any cycle overrides all: next cycle is IDLE with reset values, and no Done for the aborted op.

## Structure
- Package hilo_pkg:
  - ALUControl code localparams, shared with the ALU control decoder so encodings stay single-source.
  - State enum IDLE/CALC/FINISH.
  - WIDTH default.
- Sub-module mult_iter_32: the shift-add datapath (multiplicand, multiplier shift register, 64-bit partial product, counter) with start/last handshake. The parent owns the FSM, sign fix-up, accumulate and HI/LO.

## Test plan
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; Done exactly 34 cycles after issue, Busy high for 33 cycles.
- MULT A=0x80000000 B=0x80000000 → HI=0x40000000, LO=0. MULT A=-3 B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MTHI 0, MTLO 10, MADD 2×3 → LO=16. Then MSUB 4×5 → HI=0xFFFFFFFF, LO=0xFFFFFFFC. Then MFLO → Result=0xFFFFFFFC with ResultValid one cycle after issue.
- MUL A=7 B=0xFFFFFFFE → Result=0xFFFFFFF2 and ResultValid at t+34; HI/LO unchanged from prior values.
- MFLO with OpValid during Busy → ignored, no extra Done. Rst in CALC cycle 10 → next cycle Busy=0, HI=LO=Result=0, and no Done ever appears.
- New MULTU issued in the Done cycle of the previous MULT → accepted; second Done 34 cycles later with the correct product; an unlisted code (0x00) with OpValid → no state change.
